// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and core status of the loader.
// Latency: wires only; timing is set by the loader that drives the outputs.
// Backpressure: none; the loader takes every valid byte in the cycle it is presented.
interface imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              pc_reset;
   logic              done;
   logic              error;

   // Stream source / memory observer side
   modport master (
      output start, byte_in, byte_valid,
      input  imem_we, imem_addr, imem_wdata, pc_reset, done, error
   );

   // Loader side
   modport slave (
      input  start, byte_in, byte_valid,
      output imem_we, imem_addr, imem_wdata, pc_reset, done, error
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length header, little-endian payload words into imem, XOR checksum gate on pc_reset.
// Latency: a word write is registered and appears the cycle after its 4th byte; status one cycle after its byte.
// Backpressure: none; every valid byte is consumed at once, start wins over byte_valid and drops that byte.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   imem_loader_if.slave  ld_if
);
   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_CHECK,
      S_RUN,
      S_ERR
   } state_t;

   localparam int          CW  = ADDR_W + 1;
   localparam logic [31:0] CAP = 32'd1 << ADDR_W;

   state_t            state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [1:0]        idx_q, idx_d;
   logic [CW-1:0]     wcnt_q, wcnt_d;
   logic [7:0]        csum_q, csum_d;
   logic [23:0]       lanes_q, lanes_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [15:0]       hdr_count;

   // The full word count as it stands once the high header byte arrives
   assign hdr_count = {ld_if.byte_in, count_q[7:0]};

   // State and datapath registers; async reset puts the core on hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_LEN0;
         count_q <= '0;
         idx_q   <= '0;
         wcnt_q  <= '0;
         csum_q  <= '0;
         lanes_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         wcnt_q  <= wcnt_d;
         csum_q  <= csum_d;
         lanes_q <= lanes_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state: header parse, word assembly with one-cycle write strobe, checksum verdict
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      csum_d  = csum_q;
      lanes_d = lanes_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (ld_if.start) begin
         // Restart drops any partial word; already-written words stay in memory
         state_d = S_LEN0;
         count_d = '0;
         idx_d   = '0;
         wcnt_d  = '0;
         csum_d  = '0;
         lanes_d = '0;
      end else if (ld_if.byte_valid) begin
         case (state_q)
            S_LEN0: begin
               count_d[7:0] = ld_if.byte_in;
               state_d      = S_LEN1;
            end
            S_LEN1: begin
               count_d[15:8] = ld_if.byte_in;
               if (32'(hdr_count) > CAP) begin
                  state_d = S_ERR;
               end else if (hdr_count == 16'd0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               csum_d = csum_q ^ ld_if.byte_in;
               idx_d  = idx_q + 2'd1;
               case (idx_q)
                  2'd0: lanes_d[7:0]   = ld_if.byte_in;
                  2'd1: lanes_d[15:8]  = ld_if.byte_in;
                  2'd2: lanes_d[23:16] = ld_if.byte_in;
                  default: begin
                     we_d    = 1'b1;
                     addr_d  = wcnt_q[ADDR_W-1:0];
                     wdata_d = {ld_if.byte_in, lanes_q};
                     wcnt_d  = wcnt_q + CW'(1);
                     if (32'(wcnt_q) + 32'd1 == 32'(count_q)) begin
                        state_d = S_CHECK;
                     end
                  end
               endcase
            end
            S_CHECK: begin
               state_d = (ld_if.byte_in == csum_q) ? S_RUN : S_ERR;
            end
            default: begin
               // RUN and ERR ignore the stream until restarted
            end
         endcase
      end
   end

   assign ld_if.imem_we    = we_q;
   assign ld_if.imem_addr  = addr_q;
   assign ld_if.imem_wdata = wdata_q;
   assign ld_if.pc_reset   = (state_q != S_RUN);
   assign ld_if.done       = (state_q == S_RUN);
   assign ld_if.error      = (state_q == S_ERR);
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed images plus random payloads against a word-level model.
// Latency: writes and status are sampled on the falling edge after the accepting rising edge.
// Backpressure: none; the bench inserts random idle gaps between bytes.
module tb_imem_loader;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(AW)) bus ();
   imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .ld_if(bus));

   int total = 0;
   int bad = 0;

   // Write observer: records every strobed write and flags strobes longer than one cycle
   int          cyc = 0;
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   int          got_cyc[$];
   int          we_long = 0;
   logic        we_prev = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.imem_we === 1'b1) begin
         got_addr.push_back(32'(bus.imem_addr));
         got_data.push_back(bus.imem_wdata);
         got_cyc.push_back(cyc);
         if (we_prev) we_long = we_long + 1;
      end
      we_prev = (bus.imem_we === 1'b1);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
      we_long = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) @(negedge clk);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      @(negedge clk);
      bus.byte_valid = 1'b0;
   endtask

   task automatic pulse_start(input bit with_byte);
      bus.start      = 1'b1;
      bus.byte_valid = with_byte;
      bus.byte_in    = 8'h05;
      @(negedge clk);
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
   endtask

   task automatic rand_payload(input int words, output logic [7:0] pay[$]);
      pay.delete();
      for (int i = 0; i < 4 * words; i++) pay.push_back(8'($urandom));
   endtask

   // Model: an image of cnt words is accepted only if cnt fits the memory; word i goes to
   // address i as the little-endian pack of payload bytes 4i..4i+3; done iff the sent
   // checksum equals the XOR of all payload bytes.
   task automatic run_image(input string tag, input int cnt, input logic [7:0] pay[$],
                            input logic [7:0] csum_xor, input int maxgap, input bit with_byte);
      bit          ovf;
      int          exp_n;
      logic [7:0]  xsum;
      logic [31:0] w;
      bit          exp_done;
      pulse_start(with_byte);
      clear_obs();
      ovf   = cnt > (1 << AW);
      exp_n = ovf ? 0 : cnt;
      xsum  = 8'h00;
      foreach (pay[i]) xsum = xsum ^ pay[i];
      exp_done = !ovf && (csum_xor == 8'h00);
      send_byte(8'(cnt), maxgap);
      send_byte(8'(cnt >> 8), maxgap);
      if (!ovf) begin
         foreach (pay[i]) send_byte(pay[i], maxgap);
         send_byte(xsum ^ csum_xor, maxgap);
      end
      repeat (3) @(negedge clk);
      chk({tag, ".nwrites"}, 32'(got_addr.size()), 32'(exp_n));
      for (int i = 0; i < exp_n && i < got_addr.size(); i++) begin
         w = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
         chk($sformatf("%s.addr%0d", tag, i), got_addr[i], 32'(i));
         chk($sformatf("%s.data%0d", tag, i), got_data[i], w);
         if (maxgap == 0 && i > 0)
            chk($sformatf("%s.gap%0d", tag, i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd4);
      end
      chk({tag, ".we_width"}, 32'(we_long), 32'd0);
      chk({tag, ".done"}, 32'(bus.done), 32'(exp_done));
      chk({tag, ".error"}, 32'(bus.error), 32'(!exp_done));
      chk({tag, ".pc_reset"}, 32'(bus.pc_reset), 32'(!exp_done));
   endtask

   initial begin
      logic [7:0] p[$];
      logic [7:0] hdr_partial[$];
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;

      // Reset values
      #12;
      chk("rst.pc_reset", 32'(bus.pc_reset), 32'd1);
      chk("rst.we", 32'(bus.imem_we), 32'd0);
      chk("rst.addr", 32'(bus.imem_addr), 32'd0);
      chk("rst.wdata", bus.imem_wdata, 32'd0);
      chk("rst.done", 32'(bus.done), 32'd0);
      chk("rst.error", 32'(bus.error), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reference two-word image, continuous stream
      p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_image("img2", 2, p, 8'h00, 0, 1'b0);
      if (got_data.size() == 2) begin
         chk("img2.word0", got_data[0], 32'h44332211);
         chk("img2.word1", got_data[1], 32'hDDCCBBAA);
      end else begin
         chk("img2.words_present", 32'(got_data.size()), 32'd2);
      end

      // Restart after a good load puts the core back on hold
      pulse_start(1'b0);
      chk("start.pc_reset", 32'(bus.pc_reset), 32'd1);
      chk("start.done", 32'(bus.done), 32'd0);

      // Bad checksum, overflow, full capacity, empty images
      run_image("badsum", 2, p, 8'h01, 0, 1'b0);
      p.delete();
      run_image("ovf257", 257, p, 8'h00, 0, 1'b0);
      rand_payload(256, p);
      run_image("full256", 256, p, 8'h00, 0, 1'b0);
      if (got_addr.size() == 256) chk("full256.last_addr", got_addr[255], 32'h0000_00FF);
      p.delete();
      run_image("empty_ok", 0, p, 8'h00, 0, 1'b0);
      run_image("empty_bad", 0, p, 8'h5A, 0, 1'b0);

      // Random gaps between bytes
      rand_payload(6, p);
      run_image("gaps_ok", 6, p, 8'h00, 3, 1'b0);
      rand_payload(5, p);
      run_image("gaps_bad", 5, p, 8'($urandom_range(1, 255)), 4, 1'b0);

      // Restart in the middle of the payload
      pulse_start(1'b0);
      clear_obs();
      hdr_partial = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      foreach (hdr_partial[i]) send_byte(hdr_partial[i], 0);
      pulse_start(1'b1);
      repeat (2) @(negedge clk);
      chk("abort.nwrites", 32'(got_addr.size()), 32'd1);
      chk("abort.pc_reset", 32'(bus.pc_reset), 32'd1);
      chk("abort.done", 32'(bus.done), 32'd0);
      chk("abort.error", 32'(bus.error), 32'd0);
      rand_payload(3, p);
      run_image("after_abort", 3, p, 8'h00, 2, 1'b1);

      // Asynchronous reset while a write strobe is up
      pulse_start(1'b0);
      clear_obs();
      hdr_partial = '{8'h03, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      foreach (hdr_partial[i]) send_byte(hdr_partial[i], 0);
      chk("arst.pre_we", 32'(bus.imem_we), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst.we", 32'(bus.imem_we), 32'd0);
      chk("arst.addr", 32'(bus.imem_addr), 32'd0);
      chk("arst.wdata", bus.imem_wdata, 32'd0);
      chk("arst.pc_reset", 32'(bus.pc_reset), 32'd1);
      chk("arst.done", 32'(bus.done), 32'd0);
      chk("arst.error", 32'(bus.error), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      rand_payload(4, p);
      run_image("after_arst", 4, p, 8'h00, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
